shift_add_multiplier: RTL

Sequential shift-and-add multiplier: the inverse of the arithmetic unit's iterative divider. It forms a 2*WIDTH-bit product of two WIDTH-bit operands over WIDTH clock cycles, using a start/busy/done handshake. It sits beside the divider in the arithmetic unit and reports status on a 2-bit error vector of the same shape.

---
 rtl/shift_add_multiplier.sv | 129 ++++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH iterations, start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module shift_add_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           error
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   product_q;
    logic            busy_q;
    logic            done_q;
    logic [1:0]      error_q;

    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    result_d;
    logic             ovf_d;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             last;

    assign acc_d = acc_q + (b_q[0] ? a_q : '0);
    assign last  = (cnt_q == CW'(1));

`ifdef MULT_SIGNED_EN
    logic sign_q;
    logic sign_d;

    // 2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    assign mag_a = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;
    assign mag_b = multiplier[WIDTH-1] ? (~multiplier + WIDTH'(1)) : multiplier;
    assign sign_d = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    assign result_d = sign_q ? (~acc_d + PW'(1)) : acc_d;
    assign ovf_d = !((&result_d[PW-1:WIDTH-1]) || ~(|result_d[PW-1:WIDTH-1]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
        end else if (start && state_q != S_RUN) begin
            sign_q <= sign_d;
        end
    end
`else
    assign mag_a    = multiplicand;
    assign mag_b    = multiplier;
    assign result_d = acc_d;
    assign ovf_d    = |result_d[PW-1:WIDTH];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 2'b00;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= {{WIDTH{1'b0}}, mag_a};
                        b_q     <= mag_b;
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        error_q <= 2'b00;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - CW'(1);
                    // a request while running is dropped but remembered
                    if (start) begin
                        error_q[1] <= 1'b1;
                    end
                    if (last) begin
                        product_q  <= result_d;
                        error_q[0] <= ovf_d;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule
